ahb_regfile_slave: RTL

AHB-Lite responder holding a small array of 32-bit registers, with a configurable number of wait states and a two-cycle ERROR response. It sits on the bus as the counterpart to the behavioural AHB initiator in the block-level benches. It gives that initiator a target that exercises HREADYOUT stalls, HRESP errors, byte lanes and address/data pipelining, which the zero-wait SSRAM bridge never produces. It is also used as a scratch register bank in the chip.

---
 rtl/ahb_regfile_slave.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/ahb_regfile_slave.sv
// AHB-Lite register-file responder: NREGS x 32-bit registers, WAIT wait
// states on every OKAY transfer, two-cycle ERROR response for bad accesses.
module ahb_regfile_slave #(
  parameter int unsigned AW    = 12,
  parameter int unsigned NREGS = 16,
  parameter int unsigned WAIT  = 0
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          HSEL,
  input  logic [AW-1:0] HADDR,
  input  logic [1:0]    HTRANS,
  input  logic [2:0]    HSIZE,
  input  logic          HWRITE,
  input  logic [31:0]   HWDATA,
  input  logic          HREADY,
  output logic [31:0]   HRDATA,
  output logic          HREADYOUT,
  output logic          HRESP
);

  localparam int unsigned   IW      = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam logic [AW-2:0] NREGS_W = (AW-1)'(NREGS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAITS,
    S_DATA,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [3:0]    be_q, be_d;
  logic          write_q, write_d;
  logic [31:0]   regs_q [NREGS];
  logic [31:0]   regs_d [NREGS];

  logic          accept;
  logic          bad;
  logic [3:0]    lanes;
  logic          unused_htrans0;

  assign accept         = HSEL & HREADY & HTRANS[1];
  assign unused_htrans0 = HTRANS[0];

  // Classify the address phase: byte-lane enables and error detection.
  // Size and low address bits are folded into a lane mask at accept time.
  always_comb begin
    lanes = '0;
    bad   = 1'b0;
    case (HSIZE)
      3'd0: lanes = 4'b0001 << HADDR[1:0];
      3'd1: begin
        lanes = HADDR[1] ? 4'b1100 : 4'b0011;
        bad   = HADDR[0];
      end
      3'd2: begin
        lanes = '1;
        bad   = |HADDR[1:0];
      end
      default: bad = 1'b1;
    endcase
    if ({1'b0, HADDR[AW-1:2]} >= NREGS_W) bad = 1'b1;
  end

  // Transfer sequencing: wait countdown, error pair, pipelined accepts.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    be_d    = be_q;
    write_d = write_q;
    case (state_q)
      S_WAITS: begin
        if (cnt_q == 4'd1) begin
          state_d = S_DATA;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ERR1:  state_d = S_ERR2;
      default: state_d = S_IDLE;
    endcase
    if (accept && HREADYOUT) begin
      idx_d   = HADDR[IW+1:2];
      be_d    = lanes;
      write_d = HWRITE;
      if (bad) begin
        state_d = S_ERR1;
      end else if (WAIT == 0) begin
        state_d = S_DATA;
      end else begin
        state_d = S_WAITS;
        cnt_d   = 4'(WAIT);
      end
    end
  end

  // Write commit on the completing data cycle, enabled lanes only.
  always_comb begin
    regs_d = regs_q;
    if (state_q == S_DATA && write_q) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (be_q[b]) regs_d[idx_q][8*b +: 8] = HWDATA[8*b +: 8];
      end
    end
  end

  // State, capture and register storage with async active-low reset.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      be_q    <= '0;
      write_q <= 1'b0;
      for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      be_q    <= be_d;
      write_q <= write_d;
      regs_q  <= regs_d;
    end
  end

  // Bus outputs decoded from the current state.
  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    HRDATA    = '0;
    case (state_q)
      S_WAITS: HREADYOUT = 1'b0;
      S_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
      end
      S_ERR2:  HRESP = 1'b1;
      S_DATA:  HRDATA = regs_q[idx_q];
      default: ;
    endcase
  end

endmodule
